phase_acc: RTL and testbench
============================

// Module: phase_acc
// PURPOSE
//  Phase accumulator that generates the 8-bit count address and 2-bit waveform select for the lutSaw/LUT stage.
//  An ACC_W-bit accumulator adds a tuning word every clock; count is the top OUT_W accumulator bits.
//  Tuning-word and select changes are shadowed and take effect only at a phase wrap, so the LUT output never glitches mid-period.
//  Start/stop control; stop is deferred to the end of the current period.
// PARAMETERS
//  ACC_W    16     accumulator width; must be >= OUT_W
//  OUT_W    8      count width presented to the LUT
//  SEL_RST  2'b11  sel value after reset (saw waveform)
// PORTS
//  clk       in   1      clock; single clock domain, all logic rising-edge
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      pulse: begin/resume generation
//  stop      in   1      pulse: finish current period, then halt
//  tw        in   ACC_W  tuning word (phase increment per clk)
//  tw_load   in   1      capture tw into shadow register
//  sel_in    in   2      requested waveform select
//  sel_load  in   1      capture sel_in into shadow register
//  count     out  OUT_W  acc[ACC_W-1 -: OUT_W], registered
//  sel       out  2      active waveform select, registered
//  wrap      out  1      1-cycle pulse, accumulator overflowed this edge
//  busy      out  1      1 in RUN or DRAIN
//  pending   out  1      tw or sel shadow not yet applied
// BEHAVIOUR
//  Reset (async, rst_n=0): acc=0, count=0, tw_active=0, tw_shadow=0, sel=SEL_RST, sel_shadow=SEL_RST,
//   wrap=0, busy=0, pending=0, state=IDLE. Reset mid-operation aborts immediately, with no drain.
//  States: IDLE, RUN, DRAIN.
//   IDLE:  acc held at 0. start=1 and stop=0 -> RUN. start&stop same cycle -> stay IDLE.
//   RUN:   stop=1 -> DRAIN (stop wins over start). start ignored.
//   DRAIN: start=1 and stop=0 -> RUN (cancel stop). On the wrap edge -> IDLE, acc<=0.
//          If tw_active==0 -> IDLE next edge.
//  Accumulate (RUN/DRAIN): {carry,acc} <= acc + tw_active, modulo 2^ACC_W; wrap <= carry.
//   count is a slice of the acc register, so latency is 1 clk from tw_active to count change.
//  Shadow update:
//   - tw_load sets tw_shadow and tw_pend; sel_load sets sel_shadow and sel_pend.
//   - Pending values apply (tw_active<=tw_shadow, sel<=sel_shadow, pend cleared) on:
//     (a) any edge in IDLE;
//     (b) the edge where carry=1;
//     (c) any edge in RUN/DRAIN while tw_active==0 (otherwise it would never apply).
//   - The add on the wrap edge uses the old tw_active; the new increment is used from the next edge.
//   - Load on the same edge as an apply: the old shadow is applied, the new value goes to shadow,
//     and pend stays 1 until the next apply point.
//   - pending = tw_pend | sel_pend.
//  wrap stays 0 in IDLE. The wrap of the DRAIN->IDLE edge pulses normally, and count reads 0 after it.
//  tw=2^(ACC_W-1) gives a wrap every 2 clks; tw wider than the period is legal (modular).
// STRUCTURE
//  Shared package lut_wave_pkg: state enum (IDLE/RUN/DRAIN), SEL_SAW=2'b11 and other sel codes,
//   default ACC_W/OUT_W constants.
//  One sub-module, wave_shadow_reg #(W): holds the shadow value and pend flag, plus load/apply
//   ports; instantiated for tw (W=ACC_W) and sel (W=2).
//  Top holds the FSM, accumulator and output registers.
// TESTING (ACC_W=16, OUT_W=8)
//  1 Reset: rst_n=0 -> count=0, sel=2'b11, wrap=0, busy=0, pending=0.
//  2 tw=0x0100+tw_load in IDLE, start -> count steps 0,1,2..0xFF, 0;
//    wrap high exactly on the 0xFF->0x00 edge, every 256 clks.
//  3 RUN at tw=0x0100, load tw=0x0200 at count=0x40 -> pending=1, steps of +1 until wrap;
//    then pending=0 and steps of +2 (0x00,0x02,..).
//  4 sel_load sel_in=2'b01 at count=0x10 -> sel stays 2'b11 until the wrap edge, then 2'b01.
//  5 stop at count=0x80 -> busy stays 1, count runs to 0xFF, wraps;
//    then busy=0, count=0, no further change. start+stop together in IDLE -> stays IDLE.
//  6 RUN with tw_active=0, load 0x8000 -> applied next edge;
//    count alternates 0x00/0x80 with wrap every 2 clks. rst_n=0 mid-RUN -> async clear to reset values.

Source files
------------

// File: rtl/lut_wave_pkg.sv
// Shared types and constants for the phase accumulator and LUT waveform stage.
package lut_wave_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SINE = 2'b00;
  localparam logic [1:0] SEL_TRI  = 2'b01;
  localparam logic [1:0] SEL_SQR  = 2'b10;
  localparam logic [1:0] SEL_SAW  = 2'b11;

  localparam int unsigned ACC_W_DEF = 16;
  localparam int unsigned OUT_W_DEF = 8;

endpackage

// File: rtl/wave_shadow_reg.sv
// Shadow register with pending flag; a load on an apply edge keeps pend set
// so the newly captured value waits for the next apply point.
module wave_shadow_reg #(
  parameter int unsigned     W       = 8,
  parameter logic [W-1:0]    RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         apply,
  output logic [W-1:0] shadow,
  output logic         pend
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= RST_VAL;
      pend   <= 1'b0;
    end else begin
      if (load) begin
        shadow <= din;
        pend   <= 1'b1;
      end else if (apply) begin
        pend   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/phase_acc.sv
// Phase accumulator producing the LUT count address and waveform select,
// with wrap-aligned tuning/select updates and end-of-period stop.
module phase_acc
  import lut_wave_pkg::*;
#(
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned OUT_W   = OUT_W_DEF,
  parameter logic [1:0]  SEL_RST = SEL_SAW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [ACC_W-1:0] tw,
  input  logic             tw_load,
  input  logic [1:0]       sel_in,
  input  logic             sel_load,
  output logic [OUT_W-1:0] count,
  output logic [1:0]       sel,
  output logic             wrap,
  output logic             busy,
  output logic             pending
);

  state_t           state, state_nx;
  logic [ACC_W-1:0] acc, acc_nx;
  logic [ACC_W-1:0] tw_active, tw_shadow;
  logic [1:0]       sel_shadow;
  logic [ACC_W:0]   sum;
  logic             running, carry, tw_zero, apply, wrap_nx;
  logic             tw_pend, sel_pend;

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, tw_active};
    running = (state != IDLE);
    carry   = running & sum[ACC_W];
    tw_zero = (tw_active == '0);
    // A zero increment never wraps, so it must not block pending updates.
    apply   = !running | carry | tw_zero;
  end

  always_comb begin
    state_nx = state;
    acc_nx   = sum[ACC_W-1:0];
    wrap_nx  = carry;
    unique case (state)
      IDLE: begin
        acc_nx  = '0;
        wrap_nx = 1'b0;
        if (start && !stop) state_nx = RUN;
      end
      RUN: begin
        if (stop) state_nx = DRAIN;
      end
      DRAIN: begin
        if (start && !stop) begin
          state_nx = RUN;
        end else if (carry || tw_zero) begin
          state_nx = IDLE;
          acc_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        acc_nx   = '0;
        wrap_nx  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      wrap      <= 1'b0;
      tw_active <= '0;
      sel       <= SEL_RST;
    end else begin
      state <= state_nx;
      acc   <= acc_nx;
      wrap  <= wrap_nx;
      if (apply) begin
        tw_active <= tw_shadow;
        sel       <= sel_shadow;
      end
    end
  end

  wave_shadow_reg #(.W(ACC_W), .RST_VAL('0)) u_tw_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (tw_load),
    .din    (tw),
    .apply  (apply),
    .shadow (tw_shadow),
    .pend   (tw_pend)
  );

  wave_shadow_reg #(.W(2), .RST_VAL(SEL_RST)) u_sel_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (sel_load),
    .din    (sel_in),
    .apply  (apply),
    .shadow (sel_shadow),
    .pend   (sel_pend)
  );

  assign count   = acc[ACC_W-1 -: OUT_W];
  assign busy    = running;
  assign pending = tw_pend | sel_pend;

endmodule

// File: tb/tb_phase_acc.sv
// Scoreboard bench for phase_acc: a cycle model pushes expected outputs per
// driven edge, which are popped and compared after the edge, plus directed checks.
module tb_phase_acc;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, tw_load, sel_load;
  logic [15:0] tw;
  logic [1:0]  sel_in;
  logic [7:0]  count;
  logic [1:0]  sel;
  logic        wrap, busy, pending;

  int checks   = 0;
  int failures = 0;

  phase_acc #(.ACC_W(16), .OUT_W(8), .SEL_RST(2'b11)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .tw       (tw),
    .tw_load  (tw_load),
    .sel_in   (sel_in),
    .sel_load (sel_load),
    .count    (count),
    .sel      (sel),
    .wrap     (wrap),
    .busy     (busy),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 running, 2 draining
  int          m_mode;
  logic [15:0] m_acc, m_tw, m_tws;
  logic [1:0]  m_sel, m_sels;
  logic        m_twp, m_selp, m_wrap;
  logic [12:0] exp_q[$];

  task automatic model_reset();
    m_mode = 0; m_acc = '0; m_tw = '0; m_tws = '0;
    m_sel = 2'b11; m_sels = 2'b11; m_twp = 1'b0; m_selp = 1'b0; m_wrap = 1'b0;
  endtask

  function automatic logic [12:0] model_obs();
    return {m_acc[15:8], m_sel, m_wrap, logic'(m_mode != 0), m_twp | m_selp};
  endfunction

  task automatic model_step();
    int   nxt_acc;
    logic ovf, upd;
    nxt_acc = int'(m_acc) + int'(m_tw);
    ovf     = (m_mode != 0) && (nxt_acc >= 65536);
    upd     = (m_mode == 0) || ovf || (m_tw == 16'h0);
    if (m_mode == 0) begin
      m_wrap = 1'b0;
      m_acc  = '0;
      if (start && !stop) m_mode = 1;
    end else begin
      m_wrap = ovf;
      m_acc  = nxt_acc[15:0];
      if (m_mode == 1) begin
        if (stop) m_mode = 2;
      end else if (start && !stop) begin
        m_mode = 1;
      end else if (ovf || m_tw == 16'h0) begin
        m_mode = 0;
        m_acc  = '0;
      end
    end
    if (upd) begin
      m_tw  = m_tws;
      m_sel = m_sels;
    end
    if (tw_load) begin m_tws = tw; m_twp = 1'b1; end
    else if (upd) m_twp = 1'b0;
    if (sel_load) begin m_sels = sel_in; m_selp = 1'b1; end
    else if (upd) m_selp = 1'b0;
  endtask

  task automatic tick();
    model_step();
    exp_q.push_back(model_obs());
    @(posedge clk);
    #1;
    check_eq("cycle", {count, sel, wrap, busy, pending}, exp_q.pop_front());
  endtask

  task automatic run_until_count(input logic [7:0] target, input int budget);
    for (int i = 0; i < budget && count !== target; i++) tick();
    check_eq("reach_count", count, target);
  endtask

  task automatic run_until_wrap(input int budget);
    for (int i = 0; i < budget && wrap !== 1'b1; i++) tick();
    check_eq("reach_wrap", wrap, 1'b1);
  endtask

  initial begin
    int last_wrap;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; tw_load = 1'b0; sel_load = 1'b0;
    tw = '0; sel_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", count, 8'h00);
    check_eq("rst_sel", sel, 2'b11);
    check_eq("rst_wrap", wrap, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_pending", pending, 1'b0);
    rst_n = 1'b1;

    // basic saw at +1 per clk
    tw = 16'h0100; tw_load = 1'b1; tick(); tw_load = 1'b0;
    check_eq("idle_load_pending", pending, 1'b1);
    tick();
    check_eq("idle_apply_pending", pending, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    last_wrap = -1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (wrap) begin
        check_eq("wrap_count_zero", count, 8'h00);
        if (last_wrap >= 0) check_eq("wrap_period", i - last_wrap, 256);
        last_wrap = i;
      end
    end

    // tuning word change waits for the wrap
    run_until_count(8'h40, 300);
    tw = 16'h0200; tw_load = 1'b1; tick(); tw_load = 1'b0;
    check_eq("tw_pending", pending, 1'b1);
    tick();
    check_eq("tw_old_step", count, 8'h42);
    run_until_wrap(300);
    check_eq("tw_applied_pending", pending, 1'b0);
    tick();
    check_eq("tw_new_step", count, 8'h02);

    // select change waits for the wrap
    run_until_count(8'h10, 300);
    sel_in = 2'b01; sel_load = 1'b1; tick(); sel_load = 1'b0;
    for (int i = 0; i < 300 && wrap !== 1'b1; i++) begin
      check_eq("sel_held", sel, 2'b11);
      tick();
    end
    check_eq("sel_wrap_seen", wrap, 1'b1);
    check_eq("sel_applied", sel, 2'b01);

    // stop drains to end of period
    run_until_count(8'h80, 300);
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("drain_busy", busy, 1'b1);
    run_until_wrap(300);
    check_eq("drain_done_busy", busy, 1'b0);
    check_eq("drain_done_count", count, 8'h00);
    repeat (5) tick();
    check_eq("idle_count", count, 8'h00);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_eq("start_stop_idle", busy, 1'b0);
    tick();

    // zero increment, then half-period increment
    tw = 16'h0000; tw_load = 1'b1; tick(); tw_load = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    check_eq("zero_tw_count", count, 8'h00);
    tw = 16'h8000; tw_load = 1'b1; tick(); tw_load = 1'b0;
    tick();
    check_eq("zero_tw_applied", pending, 1'b0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("half_count", count, (i % 2 == 0) ? 8'h80 : 8'h00);
      check_eq("half_wrap", wrap, (i % 2 == 1) ? 1'b1 : 1'b0);
    end

    // async reset mid-run
    tick();
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_count", count, 8'h00);
    check_eq("arst_sel", sel, 2'b11);
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_wrap", wrap, 1'b0);
    check_eq("arst_pending", pending, 1'b0);
    model_reset();
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
